// File: rtl/adler32_job_arbiter.sv
// Round-robin arbiter sharing one Adler-32 engine among NUM_REQ requesters.
// Optional WAIT-state watchdog is enabled with `define ADLER_ARB_WATCHDOG_EN.
module adler32_job_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WD_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  req_size,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     data_rd,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            checksum_out,
    output logic                   busy,
    output logic                   eng_rst_n,
    output logic                   eng_size_valid,
    output logic [31:0]            eng_size,
    output logic                   eng_data_start,
    output logic [7:0]             eng_data,
    input  logic [31:0]            eng_checksum,
    input  logic                   eng_checksum_valid,
    output logic                   err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WD_CYCLES < 1) begin : g_param_chk
        $error("adler32_job_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_STREAM = 3'd4,
        ST_WAIT   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ZERO   = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        g_q, g_d;
    logic [IW-1:0]        last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [31:0]          size_q, size_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          sum_q, sum_d;

    logic                 pick_vld_s;
    logic [IW-1:0]        pick_idx_s;
    logic [IW-1:0]        cand_s;
    logic [31:0]          pick_size_s;

`ifdef ADLER_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0]       wd_q, wd_d;
    logic                 err_q, err_d;
`endif

    // Round-robin pick: first pending request after the previous owner, with wrap.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        cand_s     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IW'((int'(last_q) + k) % NUM_REQ);
            if (!pick_vld_s && req[cand_s]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = cand_s;
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
        pick_size_s = req_size[32*pick_idx_s +: 32];
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        grant_d = grant_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
`ifdef ADLER_ARB_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    g_d     = pick_idx_s;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    cnt_d   = pick_size_s;
                    if (pick_size_s == 32'd0) begin
                        state_d = ST_ZERO;
                    end else begin
                        size_d  = pick_size_s;
                        state_d = ST_CLR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR:   state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = ST_STREAM;
            ST_STREAM: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = ST_WAIT;
`ifdef ADLER_ARB_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WAIT: begin
                if (eng_checksum_valid) begin
                    sum_d   = eng_checksum;
                    state_d = ST_DONE;
`ifdef ADLER_ARB_WATCHDOG_EN
                end else if (wd_q == WDW'(WD_CYCLES - 1)) begin
                    sum_d   = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d    = wd_q + {{(WDW-1){1'b0}}, 1'b1};
                    state_d = ST_WAIT;
                end
`else
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_DONE: begin
                last_d  = g_q;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            ST_ZERO: begin
                sum_d   = 32'h0000_0001;
                state_d = ST_DONE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            size_q  <= 32'd0;
            cnt_q   <= 32'd0;
            sum_q   <= 32'd0;
`ifdef ADLER_ARB_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
`ifdef ADLER_ARB_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode directly from registered state; eng_rst_n also follows rst_n.
    assign grant          = grant_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE)   ? grant_q : {NUM_REQ{1'b0}};
    assign data_rd        = (state_q == ST_STREAM) ? grant_q : {NUM_REQ{1'b0}};
    assign eng_rst_n      = rst_n & (state_q != ST_CLR);
    assign eng_size_valid = (state_q == ST_LOAD);
    assign eng_size       = size_q;
    assign eng_data_start = (state_q == ST_START);
    assign eng_data       = (state_q == ST_STREAM) ? req_data[8*g_q +: 8] : 8'h00;
    assign checksum_out   = sum_q;

`ifdef ADLER_ARB_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adler32_job_arbiter.sv
// Self-checking bench for adler32_job_arbiter with a behavioural Adler-32 engine
// and per-requester byte memories; watchdog case runs when ADLER_ARB_WATCHDOG_EN is set.
module tb_adler32_job_arbiter;

    localparam int NR = 4;
    localparam int WD = 16;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*32-1:0]  req_size = '0;
    logic [NR*8-1:0]   req_data;
    logic [NR-1:0]     data_rd, grant, done;
    logic [31:0]       checksum_out;
    logic              busy, eng_rst_n, eng_size_valid, eng_data_start, err;
    logic [31:0]       eng_size;
    logic [7:0]        eng_data;
    logic [31:0]       eng_checksum = 32'd0;
    logic              eng_checksum_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    adler32_job_arbiter #(.NUM_REQ(NR), .WD_CYCLES(WD)) dut (
        .clock(clock), .rst_n(rst_n), .req(req), .req_size(req_size),
        .req_data(req_data), .data_rd(data_rd), .grant(grant), .done(done),
        .checksum_out(checksum_out), .busy(busy), .eng_rst_n(eng_rst_n),
        .eng_size_valid(eng_size_valid), .eng_size(eng_size),
        .eng_data_start(eng_data_start), .eng_data(eng_data),
        .eng_checksum(eng_checksum), .eng_checksum_valid(eng_checksum_valid),
        .err(err)
    );

    // Requester side: byte memory per port, pointer advances on data_rd, rewinds when idle
    logic [7:0]  mem [NR][16];
    int unsigned ptr [NR];

    always @(posedge clock) begin
        for (int i = 0; i < NR; i++) begin
            if (!req[i]) ptr[i] <= 0;
            else if (data_rd[i]) ptr[i] <= ptr[i] + 1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) req_data[i*8 +: 8] = mem[i][ptr[i] % 16];
    end

    // Engine model: result valid 3 cycles after the last byte is consumed
    logic [31:0] ea = 32'd1, eb = 32'd0, esz = 32'd0, erem = 32'd0;
    int          elat = 0;
    logic        mute = 1'b0;

    function automatic logic [31:0] md(input logic [31:0] x);
        return (x >= 32'd65521) ? x - 32'd65521 : x;
    endfunction

    always @(posedge clock) begin
        eng_checksum_valid <= 1'b0;
        if (!eng_rst_n) begin
            ea <= 32'd1; eb <= 32'd0; erem <= 32'd0; elat <= 0;
        end else begin
            if (eng_size_valid) esz <= eng_size;
            if (eng_data_start) begin
                erem <= esz;
            end else if (erem != 0) begin
                ea   <= md(ea + {24'd0, eng_data});
                eb   <= md(eb + md(ea + {24'd0, eng_data}));
                erem <= erem - 1;
                if (erem == 1) elat <= 3;
            end else if (elat != 0) begin
                elat <= elat - 1;
                if (elat == 1 && !mute) begin
                    eng_checksum_valid <= 1'b1;
                    eng_checksum       <= {eb[15:0], ea[15:0]};
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_bytes(input int id, input logic [71:0] s, input int len);
        for (int k = 0; k < len; k++) mem[id][k] = s[8*(len-1-k) +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {41'd0, grant, done, data_rd, busy, err, eng_rst_n,
                              eng_size_valid, eng_data_start, eng_data}, 64'd0);
        check({tag, "_data"}, {eng_size, checksum_out}, 64'd0);
    endtask

    // One job on one port; latency counted from the first cycle grant is visible
    task automatic run_job(input int id, input int size, input logic [31:0] exp_sum,
                           input int exp_lat, input logic exp_err);
        int t, lat, rd, clr_n, load_n, start_n, clr_at, load_at, start_at;
        logic seen;
        logic [47:0] exp_ctl;
        @(negedge clock);
        req_size[id*32 +: 32] = size;
        req[id] = 1'b1;
        t = 0;
        while (!grant[id] && t < 20) begin @(negedge clock); t++; end
        check("grant_seen", {63'd0, grant[id]}, 64'd1);
        lat = 0; rd = 0; seen = 1'b0;
        clr_n = 0; load_n = 0; start_n = 0; clr_at = -1; load_at = -1; start_at = -1;
        while (!seen && lat < 200) begin
            if (!eng_rst_n)     begin clr_n++;   if (clr_at < 0)   clr_at = lat;   end
            if (eng_size_valid) begin load_n++;  if (load_at < 0)  load_at = lat;  end
            if (eng_data_start) begin start_n++; if (start_at < 0) start_at = lat; end
            if (data_rd != '0) begin
                check("data_rd_onehot", 64'(data_rd), 64'(1 << id));
                if (rd < 16) check("eng_data", 64'(eng_data), 64'(mem[id][rd]));
                rd++;
            end
            if (done[id]) begin
                seen = 1'b1;
                check("done_sum", 64'(checksum_out), 64'(exp_sum));
                check("done_err", 64'(err), 64'(exp_err));
                check("done_lat", 64'(lat), 64'(exp_lat));
            end else begin
                @(negedge clock);
                lat++;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        check("rd_count", 64'(rd), 64'(size));
        exp_ctl = (size == 0) ? {8'd0, 8'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF}
                              : {8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd2};
        check("ctrl_order", 64'({8'(clr_n), 8'(load_n), 8'(start_n),
                                 8'(clr_at), 8'(load_at), 8'(start_at)}), 64'(exp_ctl));
        req[id] = 1'b0;
        @(negedge clock);
        check("grant_drop", {60'd0, grant}, 64'd0);
        check("sum_hold", 64'(checksum_out), 64'(exp_sum));
    endtask

    typedef struct {
        int          id;
        logic [71:0] data;
        int          len;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n, cyc, dn;
        logic raise0;
        int order [4];
        logic [31:0] exp_by_id [NR];

        vecs[0] = '{id: 1, data: 72'h61,                   len: 1, sum: 32'h0062_0062};
        vecs[1] = '{id: 0, data: 72'h61_6263,              len: 3, sum: 32'h024D_0127};
        vecs[2] = '{id: 3, data: 72'h57_696B_6970_6564_6961, len: 9, sum: 32'h11E6_0398};
        vecs[3] = '{id: 2, data: 72'h0,                    len: 0, sum: 32'h0000_0001};
        vecs[4] = '{id: 1, data: 72'h57_696B_6970_6564_6961, len: 9, sum: 32'h11E6_0398};
        vecs[5] = '{id: 0, data: 72'h6162,                 len: 2, sum: 32'h0126_00C4};

        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 16; k++) mem[i][k] = 8'h00;

        // Reset values, including eng_rst_n forced low by rst_n
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {62'd0, busy, eng_rst_n}, 64'd1);

        // Round robin from last_grant=3: 0, 2, 3 simultaneous; 0 re-requests after its done
        load_bytes(0, 72'h61, 1);      exp_by_id[0] = 32'h0062_0062;
        load_bytes(2, 72'h61_6263, 3); exp_by_id[2] = 32'h024D_0127;
        load_bytes(3, 72'h6162, 2);    exp_by_id[3] = 32'h0126_00C4;
        exp_by_id[1] = 32'h0;
        req_size[0*32 +: 32] = 32'd1;
        req_size[2*32 +: 32] = 32'd3;
        req_size[3*32 +: 32] = 32'd2;
        req = 4'b1101;
        n = 0; cyc = 0; raise0 = 1'b0;
        for (int i = 0; i < 4; i++) order[i] = 9;
        while (n < 4 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (raise0) begin req[0] = 1'b1; raise0 = 1'b0; end
            for (int i = 0; i < NR; i++) begin
                if (done[i]) begin
                    if (n < 4) order[n] = i;
                    n++;
                    check("rr_sum", 64'(checksum_out), 64'(exp_by_id[i]));
                    req[i] = 1'b0;
                    if (i == 0 && n == 1) raise0 = 1'b1;
                end
            end
        end
        check("rr_jobs", 64'(n), 64'd4);
        check("rr_order", {48'd0, 4'(order[0]), 4'(order[1]), 4'(order[2]), 4'(order[3])},
              {48'd0, 4'd0, 4'd2, 4'd3, 4'd0});
        req = '0;
        @(negedge clock);

        // Directed job table; latency 1 for size 0, else size+7 with this engine model
        for (int v = 0; v < 6; v++) begin
            load_bytes(vecs[v].id, vecs[v].data, vecs[v].len);
            run_job(vecs[v].id, vecs[v].len, vecs[v].sum,
                    (vecs[v].len == 0) ? 1 : vecs[v].len + 7, 1'b0);
        end

        // Reset in the middle of STREAM aborts without a done pulse
        load_bytes(1, 72'h57_696B_6970_6564_6961, 9);
        req_size[1*32 +: 32] = 32'd9;
        req[1] = 1'b1;
        cyc = 0;
        while (!data_rd[1] && cyc < 20) begin @(negedge clock); cyc++; end
        check("midrst_streaming", {63'd0, data_rd[1]}, 64'd1);
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        req[1] = 1'b0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done != '0) dn++;
        end
        check("midrst_no_done", 64'(dn), 64'd0);
        load_bytes(1, 72'h61, 1);
        run_job(1, 1, 32'h0062_0062, 8, 1'b0);

`ifdef ADLER_ARB_WATCHDOG_EN
        // Engine silent: 16 WAIT cycles then err+done with all-ones result
        mute = 1'b1;
        load_bytes(2, 72'h61_6263, 3);
        run_job(2, 3, 32'hFFFF_FFFF, 3 + 19, 1'b1);
        mute = 1'b0;
        run_job(2, 3, 32'h024D_0127, 3 + 7, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
